// File: rtl/param_fifo.sv
// param_fifo
// Parameterised synchronous FIFO with show-ahead read data, occupancy count,
// almost-full / almost-empty thresholds and one-cycle overflow / underflow
// pulses for rejected requests.
//
// Parameters:
//   WIDTH     data word width in bits
//   DEPTH     number of storage entries (power of two, >= 2)
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//
// Ports:
//   ck            clock, all state changes on the rising edge
//   reset         synchronous reset, active-low
//   flush         empties the queue; same-cycle insert/remove are ignored
//   insert        write request (data_in is stored at the tail)
//   remove        pop request (head entry is discarded)
//   data_in       write data
//   data_out      head-of-queue word, zero while empty
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy
//   overflow      pulse the cycle after an insert was rejected
//   underflow     pulse the cycle after a remove was rejected
module param_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     ck,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     insert,
    input  logic                     remove,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    logic do_push;
    logic do_pop;
    logic reject_insert;
    logic reject_remove;

    // Status flags are pure decodes of the occupancy register.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);

    // Show-ahead output; forced to zero while empty so stale memory never
    // leaks out and a same-cycle insert into an empty queue is not bypassed.
    assign data_out = empty ? '0 : mem[rp];

    // A pop only happens when there is something to pop. A push into a full
    // queue is still accepted when a pop in the same cycle frees the slot.
    assign do_pop        = remove && !empty;
    assign do_push       = insert && (!full || do_pop);
    assign reject_insert = insert && !do_push;
    assign reject_remove = remove && empty;

    // Pointer, occupancy and error-pulse registers. Reset beats flush, and
    // flush beats any insert/remove request in the same cycle.
    always_ff @(posedge ck) begin
        if (!reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= reject_insert;
            underflow <= reject_remove;
            if (do_push) begin
                wp <= wp + AW'(1);
            end
            if (do_pop) begin
                rp <= rp + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Storage array has no reset; only the pointers define what is valid.
    always_ff @(posedge ck) begin
        if (reset && !flush && do_push) begin
            mem[wp] <= data_in;
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo
// Self-checking bench for param_fifo with WIDTH=8, DEPTH=4, AF_LEVEL=3,
// AE_LEVEL=1. A queue-based reference model tracks the expected contents
// and error pulses; directed scenarios are followed by a randomized run.
module tb_param_fifo;

    logic       ck;
    logic       reset;
    logic       flush;
    logic       insert;
    logic       remove;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] q[$];
    logic       exp_ovf;
    logic       exp_unf;

    param_fifo #(
        .WIDTH(8),
        .DEPTH(4),
        .AF_LEVEL(3),
        .AE_LEVEL(1)
    ) dut (
        .ck(ck),
        .reset(reset),
        .flush(flush),
        .insert(insert),
        .remove(remove),
        .data_in(data_in),
        .data_out(data_out),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // Hard bound on the whole run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model: the queue holds the expected contents; requests are resolved
    // with the FIFO's rules (pop frees a slot for a same-cycle push).
    task automatic apply_stimulus(input logic rst_n, input logic fl,
                                  input logic ins, input logic rem,
                                  input logic [7:0] din);
        bit can_pop;
        bit can_push;
        reset   = rst_n;
        flush   = fl;
        insert  = ins;
        remove  = rem;
        data_in = din;
        @(posedge ck);
        if (!rst_n || fl) begin
            q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            can_pop  = rem && (q.size() > 0);
            can_push = ins && ((q.size() < 4) || can_pop);
            exp_ovf  = ins && !can_push;
            exp_unf  = rem && (q.size() == 0);
            if (can_pop) void'(q.pop_front());
            if (can_push) q.push_back(din);
        end
        #1;
        reset  = 1'b1;
        flush  = 1'b0;
        insert = 1'b0;
        remove = 1'b0;
    endtask

    function automatic logic [16:0] expected_vec();
        int n;
        n = q.size();
        return {(n > 0) ? q[0] : 8'h00, 3'(n), (n == 4), (n == 0),
                (n >= 3), (n <= 1), exp_ovf, exp_unf};
    endfunction

    task automatic test_reset();
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hAA);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if ({data_out, count, full, empty, almost_full, almost_empty, overflow, underflow}
            !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got dout=%h cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b",
                     data_out, count, full, empty, almost_full, almost_empty, overflow, underflow);
        end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, vals[i]);
            tests_run++;
            if (almost_full !== (i >= 2) || full !== (i == 3) || count !== 3'(i + 1)) begin
                tests_failed++;
                $display("[TB] FAIL fill_%0d: got af=%b full=%b cnt=%0d need af=%b full=%b cnt=%0d",
                         i, almost_full, full, count, (i >= 2), (i == 3), i + 1);
            end
        end
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h55);
        tests_run++;
        if (overflow !== 1'b1 || count !== 3'd4 || data_out !== 8'h11) begin
            tests_failed++;
            $display("[TB] FAIL overflow_pulse: got ov=%b cnt=%0d dout=%h need 1/4/11",
                     overflow, count, data_out);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (overflow !== 1'b0 || count !== 3'd4) begin
            tests_failed++;
            $display("[TB] FAIL overflow_clear: got ov=%b cnt=%0d need 0/4", overflow, count);
        end
    endtask

    task automatic test_drain_underflow();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (data_out !== vals[i]) begin
                tests_failed++;
                $display("[TB] FAIL drain_%0d: got dout=%h need %h", i, data_out, vals[i]);
            end
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        end
        tests_run++;
        if (empty !== 1'b1 || data_out !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL drained_empty: got e=%b dout=%h need 1/00", empty, data_out);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tests_run++;
        if (underflow !== 1'b1 || count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL underflow_pulse: got un=%b cnt=%0d need 1/0", underflow, count);
        end
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (underflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL underflow_clear: got un=%b need 0", underflow);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] wr_val = 8'h01;
        logic [7:0] rd_val = 8'h01;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) begin
                apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, wr_val);
                wr_val++;
            end
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (data_out !== rd_val) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_r%0d_k%0d: got dout=%h need %h", r, k, data_out, rd_val);
                end
                apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
                rd_val++;
            end
        end
        tests_run++;
        if (empty !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_end_empty: got e=%b need 1", empty);
        end
    endtask

    task automatic test_simultaneous();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hA1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hA2);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'hA3);
        tests_run++;
        if (count !== 3'd2 || data_out !== 8'hA2 || overflow !== 1'b0 || underflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL both_mid: got cnt=%0d dout=%h ov=%b un=%b need 2/a2/0/0",
                     count, data_out, overflow, underflow);
        end
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hA4);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'hA6);
        tests_run++;
        if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0 || data_out !== 8'hA3) begin
            tests_failed++;
            $display("[TB] FAIL both_full: got cnt=%0d full=%b ov=%b dout=%h need 4/1/0/a3",
                     count, full, overflow, data_out);
        end
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        tests_run++;
        if (data_out !== 8'h00 || count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL full_drain_order: got cnt=%0d need 0", count);
        end
        // Present insert+remove on an empty queue; output must not bypass.
        reset   = 1'b1;
        insert  = 1'b1;
        remove  = 1'b1;
        data_in = 8'h77;
        #1;
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL no_bypass: got dout=%h need 00", data_out);
        end
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h77);
        tests_run++;
        if (count !== 3'd1 || underflow !== 1'b1 || data_out !== 8'h77) begin
            tests_failed++;
            $display("[TB] FAIL both_empty: got cnt=%0d un=%b dout=%h need 1/1/77",
                     count, underflow, data_out);
        end
    endtask

    task automatic test_flush();
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
        tests_run++;
        if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || data_out !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL flush_ins: got cnt=%0d e=%b ov=%b dout=%h need 0/1/0/00",
                     count, empty, overflow, data_out);
        end
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hD1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hD2);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hD3);
        tests_run++;
        if ({data_out, count, full, empty, almost_full, almost_empty, overflow, underflow}
            !== {8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_over_flush: got dout=%h cnt=%0d f=%b e=%b af=%b ae=%b",
                     data_out, count, full, empty, almost_full, almost_empty);
        end
    endtask

    task automatic test_random();
        logic [16:0] got;
        logic [16:0] want;
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) == 0),
                           1'($urandom), 1'($urandom), 8'($urandom));
            got  = {data_out, count, full, empty, almost_full, almost_empty, overflow, underflow};
            want = expected_vec();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d: got %h need %h", i, got, want);
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        flush   = 1'b0;
        insert  = 1'b0;
        remove  = 1'b0;
        data_in = 8'h00;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1) SHALL be supported.
REQ-002 Parameter DEPTH, default 16, number of storage entries, power of two, >=2, SHALL be supported.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold in entries, 1..DEPTH-1, SHALL be supported.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold in entries, 1..DEPTH-1, SHALL be supported.
REQ-005 The design SHALL use one clock and a synchronous, active-low reset:
  - ck  input  1  clock; all state updates on rising edge.
  - reset  input  1  synchronous reset, active-low.
REQ-006 The remaining ports SHALL be:
  - flush  input  1  clear contents.
  - insert  input  1  write request.
  - remove  input  1  read/pop request.
  - data_in  input  WIDTH  write data.
  - data_out  output  WIDTH  head-of-queue word.
  - full  output  1  count == DEPTH.
  - empty  output  1  count == 0.
  - almost_full  output  1  count >= AF_LEVEL.
  - almost_empty  output  1  count <= AE_LEVEL.
  - count  output  log2(DEPTH)+1  current occupancy.
  - overflow  output  1  one-cycle pulse on rejected insert.
  - underflow  output  1  one-cycle pulse on rejected remove.

Function
REQ-007 Storage SHALL be a DEPTH x WIDTH array addressed by write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-008 Occupancy SHALL be held in a count register of log2(DEPTH)+1 bits; full, empty, almost_full and almost_empty SHALL be combinational decodes of count.
REQ-009 data_out SHALL show mem[rp] combinationally (show-ahead) when not empty, and all-zeros when empty.
REQ-010 Per-edge priority SHALL be: reset, then flush, then insert/remove.
REQ-011 Flush SHALL set wp=rp=count=0 and ignore same-cycle insert/remove; overflow and underflow SHALL be 0 on the next cycle; memory contents need not be cleared.
REQ-012 Insert only, not full: mem[wp]<=data_in, wp+1, count+1.
REQ-013 Insert only, full: no state change; overflow=1 on the following cycle only.
REQ-014 Remove only, not empty: rp+1, count-1.
REQ-015 Remove only, empty: no state change; underflow=1 on the following cycle only.
REQ-016 Insert and remove, 0<count<DEPTH: write and pop both occur; count unchanged.
REQ-017 Insert and remove, full: both occur (pop frees the slot written); count stays DEPTH; no overflow.
REQ-018 Insert and remove, empty: insert occurs, remove ignored; count becomes 1; underflow=1 on the following cycle; data_out SHALL NOT bypass data_in in that cycle.
REQ-019 Neither request: no state change; overflow=underflow=0.
REQ-020 Latency: a word inserted at edge N SHALL be visible on data_out after edge N when it is the head entry.
REQ-021 Ordering SHALL be strict first-in first-out across any number of pointer wraps.

Reset
REQ-022 When reset=0 at a rising edge, the block SHALL set wp=rp=count=0, overflow=underflow=0, giving empty=1, full=0, almost_empty=1, almost_full=0 and data_out=0.
REQ-023 Reset SHALL override flush, insert and remove in the same cycle.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries.
REQ-025 Reset SHALL have no asynchronous effect between clock edges.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1)
REQ-026 Reset then idle -> count=0, empty=1, almost_empty=1, full=0, data_out=0x00.
REQ-027 Insert 0x11,0x22,0x33,0x44 -> almost_full=1 after the third insert; full=1 and count=4 after the fourth; a fifth insert of 0x55 -> overflow pulse for 1 cycle, count=4, and 0x55 is never read.
REQ-028 From full, remove 4 times -> data_out sequence 0x11,0x22,0x33,0x44, then empty=1; a further remove -> underflow pulse for 1 cycle, count=0.
REQ-029 Wrap test: 10 rounds of insert 3 / remove 3 with incrementing data -> strict FIFO order with no loss.
REQ-030 Simultaneous requests: insert+remove at count=2 -> count stays 2 and head advances; at full -> count=4, no overflow; at empty -> count=1, underflow pulse, data_out=data_in only from the next cycle.
REQ-031 Flush with count=3 and insert=1 -> count=0, empty=1, no overflow; reset=0 with flush=1 and insert=1 -> reset state as in REQ-022.
